vram_arbiter: RTL

Shares the single-port video RAM between the VGA scanout fetch and two game-logic clients (sprite engine, playfield writer). Sits between the VGA counters (consuming `pixelClock` and the visible-area `state`) and the RAM primitive. Display reads have absolute priority. Clients are served round-robin, either at any free cycle or only during blanking, as configured. Registered RAM command, fixed read latency, and per-client grant/valid handshake.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/rr_arbiter_2.sv | 41 ++++
 rtl/vram_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA / VRAM definitions: timing constants, RAM geometry and the
// owner tag that travels down the arbiter's read pipeline.
package vga_pkg;

    localparam int H_VISIBLE   = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_VISIBLE   = 480;
    localparam int V_TOTAL     = 525;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 8;

    // Cycles from the arbitration decision to read data on ram_rdata.
    localparam int RD_LAT      = 2;

    // Who owns a RAM slot.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        C0   = 2'd2,
        C1   = 2'd3
    } owner_e;

    // One-hot client vector for an owner tag (zero for IDLE/DISP).
    function automatic logic [1:0] owner_to_client(input owner_e o);
        logic [1:0] v;
        v = 2'b00;
        if (o == C0) v[0] = 1'b1;
        if (o == C1) v[1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker. A client whose grant is currently high is
// masked out so a request held into its grant cycle is not served twice.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic       last_q, last_d;
    logic [1:0] elig;

    // Pick a client: single eligible wins, both eligible alternates on last.
    always_comb begin
        elig  = req & ~mask;
        grant = 2'b00;
        if (en) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember the last client served; only a real grant moves it.
    always_comb begin
        last_d = last_q;
        if (grant != 2'b00) last_d = grant[1];
    end

    // Pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_q <= 1'b0;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout reads have absolute priority,
// two game-logic clients share the remaining (or blanking-only) slots
// round-robin. The RAM command is registered; read ownership rides a
// two-stage tag pipeline so ram_rdata is steered to the right consumer.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pixelClock,
    input  logic              state,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              disp_cyc;
    logic              slot_ok;
    logic [1:0]        pick;
    owner_e            own_d;

    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]        gnt_q,       gnt_d;

    // Read-owner pipeline: [0] is the command on the RAM port, [1] is the
    // cycle its data shows on ram_rdata. Writes and idle slots carry IDLE.
    owner_e            rd_pipe_q [RD_LAT];
    owner_e            rd_pipe_d [RD_LAT];

    // Slot classification for this cycle; uses the live state input.
    always_comb begin
        disp_cyc = pixelClock && state;
        slot_ok  = !disp_cyc && (!BLANK_ONLY || !state);
    end

    rr_arbiter_2 u_rr (
        .clock (clock),
        .reset (reset),
        .en    (slot_ok),
        .req   (req),
        .mask  (gnt_q),
        .grant (pick)
    );

    // Priority mux: display, then the round-robin client, else idle.
    // Address/data hold when idle to avoid needless toggling on the RAM bus.
    always_comb begin
        own_d       = IDLE;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (disp_cyc) begin
            own_d      = DISP;
            ram_en_d   = 1'b1;
            ram_addr_d = disp_addr;
        end else if (pick[0]) begin
            own_d       = C0;
            ram_en_d    = 1'b1;
            ram_we_d    = we[0];
            ram_addr_d  = addr0;
            ram_wdata_d = wdata0;
        end else if (pick[1]) begin
            own_d       = C1;
            ram_en_d    = 1'b1;
            ram_we_d    = we[1];
            ram_addr_d  = addr1;
            ram_wdata_d = wdata1;
        end
        gnt_d = owner_to_client(own_d);
    end

    // Advance the read-owner tags; only reads produce data to steer.
    always_comb begin
        rd_pipe_d[0] = (ram_we_d || own_d == IDLE) ? IDLE : own_d;
        for (int s = 1; s < RD_LAT; s++) rd_pipe_d[s] = rd_pipe_q[s-1];
    end

    // Command registers, grant pulse and tag pipeline; reset drops in-flight reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            gnt_q       <= 2'b00;
            for (int s = 0; s < RD_LAT; s++) rd_pipe_q[s] <= IDLE;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            gnt_q       <= gnt_d;
            for (int s = 0; s < RD_LAT; s++) rd_pipe_q[s] <= rd_pipe_d[s];
        end
    end

    // ram_rdata is the shared read bus; the valids say who it belongs to.
    always_comb begin
        ram_en     = ram_en_q;
        ram_we     = ram_we_q;
        ram_addr   = ram_addr_q;
        ram_wdata  = ram_wdata_q;
        gnt        = gnt_q;
        disp_valid = (rd_pipe_q[RD_LAT-1] == DISP);
        rvalid     = owner_to_client(rd_pipe_q[RD_LAT-1]);
    end

    // Data is forwarded unregistered; the arbiter itself never inspects it.
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;

endmodule
